debounce_conditioner: RTL and testbench

- Multi-channel input conditioner for user buttons and switches; next generation of the single-direction debouncer.
- Takes WIDTH synchronized but glitchy inputs. Debounces both press and release symmetrically.
- Emits per-channel level, rising-edge pulse, falling-edge pulse and an optional auto-repeat press pulse.
- Sits between the synchronizer and the MMIO/button logic in the top level.

---
 rtl/debounce_conditioner_pkg.sv | 15 +
 rtl/debounce_channel.sv | 143 ++++++++++++++
 rtl/debounce_conditioner.sv | 54 +++++
 tb/tb_debounce_conditioner.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_conditioner_pkg.sv
// Shared types and width helpers for the debounce conditioner and its channels.
package debounce_conditioner_pkg;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_t;

   // Counter width able to hold 0..max_value-1, never narrower than one bit.
   function automatic int width_for(input int max_value);
      return (max_value > 1) ? $clog2(max_value) : 1;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced channel: agreement counter, level, edge pulses and optional auto-repeat.
module debounce_channel
   import debounce_conditioner_pkg::*;
#(
   parameter int PULSE_COUNT_MAX = 150,
   parameter int REPEAT_EN       = 0,
   parameter int REPEAT_DELAY    = 250,
   parameter int REPEAT_PERIOD   = 50
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic glitchy,
   output logic debounced,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic press_pulse
);

   localparam int PULSE_W = width_for(PULSE_COUNT_MAX);

   logic [PULSE_W-1:0] count;
   logic               level;
   logic               disagree;
   logic               at_limit;
   logic               flip;
   logic               rise_evt;
   logic               fall_evt;
   logic               rpt_pulse;

   assign disagree = (glitchy != level);
   assign at_limit = (count == PULSE_W'(PULSE_COUNT_MAX - 1));
   assign flip     = tick && disagree && at_limit;
   assign rise_evt = flip && !level;
   assign fall_evt = flip && level;

   // NOTE: state registers use non-blocking assignments so each one samples pre-edge values, independent of process order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count      <= '0;
         level      <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         rise_pulse <= rise_evt;
         fall_pulse <= fall_evt;
         if (tick) begin
            // A single agreeing tick, or the flip itself, restarts the count.
            if (!disagree || at_limit) count <= '0;
            else                       count <= count + PULSE_W'(1);
            if (flip) level <= ~level;
         end
      end
   end

   assign debounced = level;

   generate
      if (REPEAT_EN != 0) begin : g_repeat
         localparam int RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
         localparam int REPEAT_W = width_for(RPT_MAX + 1);

         rpt_state_t          state;
         rpt_state_t          state_next;
         logic [REPEAT_W-1:0] rcnt;
         logic [REPEAT_W-1:0] rcnt_next;
         logic                delay_done;
         logic                period_done;
         logic                rpt_fire;
         logic                rpt_q;

         assign delay_done  = (rcnt == REPEAT_W'(REPEAT_DELAY - 1));
         assign period_done = (rcnt == REPEAT_W'(REPEAT_PERIOD - 1));

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               state <= RPT_IDLE;
               rcnt  <= '0;
               rpt_q <= 1'b0;
            end else begin
               state <= state_next;
               rcnt  <= rcnt_next;
               rpt_q <= rpt_fire;
            end
         end

         always_comb begin
            // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
            state_next = state;
            rcnt_next  = rcnt;
            if (fall_evt) begin
               state_next = RPT_IDLE;
               rcnt_next  = '0;
            end else begin
               case (state)
                  RPT_IDLE: begin
                     if (rise_evt) begin
                        state_next = RPT_DELAY;
                        rcnt_next  = '0;
                     end
                  end
                  RPT_DELAY: begin
                     if (tick) begin
                        if (delay_done) begin
                           state_next = RPT_REPEAT;
                           rcnt_next  = '0;
                        end else begin
                           rcnt_next = rcnt + REPEAT_W'(1);
                        end
                     end
                  end
                  RPT_REPEAT: begin
                     if (tick) begin
                        if (period_done) rcnt_next = '0;
                        else             rcnt_next = rcnt + REPEAT_W'(1);
                     end
                  end
                  default: state_next = RPT_IDLE;
               endcase
            end
         end

         // A release on the same tick suppresses the repeat pulse.
         always_comb begin
            rpt_fire = 1'b0;
            if (tick && !fall_evt) begin
               case (state)
                  RPT_DELAY:  rpt_fire = delay_done;
                  RPT_REPEAT: rpt_fire = period_done;
                  default:    rpt_fire = 1'b0;
               endcase
            end
         end

         assign rpt_pulse = rpt_q;
      end else begin : g_no_repeat
         assign rpt_pulse = 1'b0;
      end
   endgenerate

   assign press_pulse = rise_pulse | rpt_pulse;

endmodule

// File: rtl/debounce_conditioner.sv
// Multi-channel button/switch conditioner: shared sample tick feeding WIDTH debounce channels.
module debounce_conditioner
   import debounce_conditioner_pkg::*;
#(
   parameter int WIDTH            = 1,
   parameter int SAMPLE_COUNT_MAX = 25000,
   parameter int PULSE_COUNT_MAX  = 150,
   parameter int REPEAT_EN        = 0,
   parameter int REPEAT_DELAY     = 250,
   parameter int REPEAT_PERIOD    = 50
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] glitchy_signal,
   output logic [WIDTH-1:0] debounced_signal,
   output logic [WIDTH-1:0] rise_pulse,
   output logic [WIDTH-1:0] fall_pulse,
   output logic [WIDTH-1:0] press_pulse
);

   localparam int SAMPLE_W = width_for(SAMPLE_COUNT_MAX);

   logic [SAMPLE_W-1:0] sample_count;
   logic                tick;

   assign tick = (sample_count == SAMPLE_W'(SAMPLE_COUNT_MAX - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       sample_count <= '0;
      else if (tick) sample_count <= '0;
      else           sample_count <= sample_count + SAMPLE_W'(1);
   end

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_ch
         debounce_channel #(
            .PULSE_COUNT_MAX (PULSE_COUNT_MAX),
            .REPEAT_EN       (REPEAT_EN),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
         ) u_channel (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .glitchy     (glitchy_signal[i]),
            .debounced   (debounced_signal[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .press_pulse (press_pulse[i])
         );
      end
   endgenerate

endmodule

// File: tb/tb_debounce_conditioner.sv
// Bench for debounce_conditioner: a plain and an auto-repeat instance share stimulus and a behavioural model.
module tb_debounce_conditioner;

   localparam int SCM = 4;
   localparam int PCM = 3;
   localparam int RD  = 2;
   localparam int RP  = 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] glitchy = 2'b00;
   logic [1:0] dbl, rise, fall, press;
   logic [1:0] dbl_r, rise_r, fall_r, press_r;

   int n_checks = 0;
   int n_pass   = 0;

   debounce_conditioner #(
      .WIDTH(2), .SAMPLE_COUNT_MAX(SCM), .PULSE_COUNT_MAX(PCM), .REPEAT_EN(0)
   ) u_dut (
      .clk(clk), .rst(rst), .glitchy_signal(glitchy),
      .debounced_signal(dbl), .rise_pulse(rise), .fall_pulse(fall), .press_pulse(press)
   );

   debounce_conditioner #(
      .WIDTH(2), .SAMPLE_COUNT_MAX(SCM), .PULSE_COUNT_MAX(PCM), .REPEAT_EN(1),
      .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
   ) u_dut_rpt (
      .clk(clk), .rst(rst), .glitchy_signal(glitchy),
      .debounced_signal(dbl_r), .rise_pulse(rise_r), .fall_pulse(fall_r), .press_pulse(press_r)
   );

   always #5 clk = ~clk;

   // Behavioural model: edges since reset, disagreeing-tick run lengths, ticks since a rise.
   int         m_edges = 0;
   logic [1:0] m_level = '0, m_rise = '0, m_fall = '0, m_rpt = '0;
   int         m_run[2]  = '{0, 0};
   int         m_held[2] = '{-1, -1};

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_edges = 0;
         m_level = '0; m_rise = '0; m_fall = '0; m_rpt = '0;
         m_run   = '{0, 0};
         m_held  = '{-1, -1};
      end else begin
         m_edges++;
         m_rise = '0; m_fall = '0; m_rpt = '0;
         if (m_edges % SCM == 0) begin
            for (int c = 0; c < 2; c++) begin
               if (glitchy[c] != m_level[c]) m_run[c]++;
               else                          m_run[c] = 0;
               if (m_run[c] == PCM) begin
                  m_run[c]   = 0;
                  m_level[c] = ~m_level[c];
                  if (m_level[c]) begin m_rise[c] = 1'b1; m_held[c] = 0;  end
                  else            begin m_fall[c] = 1'b1; m_held[c] = -1; end
               end else if (m_held[c] >= 0) begin
                  m_held[c]++;
                  if (m_held[c] == RD || (m_held[c] > RD && (m_held[c] - RD) % RP == 0))
                     m_rpt[c] = 1'b1;
               end
            end
         end
      end
   end

   logic [15:0] obs, exp_vec;
   assign obs     = {dbl, rise, fall, press, dbl_r, rise_r, fall_r, press_r};
   assign exp_vec = {m_level, m_rise, m_fall, m_rise, m_level, m_rise, m_fall, m_rise | m_rpt};

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   // Stimulus only: reset pulse, returning on the releasing negedge.
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      glitchy = 2'b00;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      glitchy = 2'b11;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== 16'h0000) $display("FAIL reset_outputs k=%0d got=%h exp=0000", k, obs);
         else n_pass++;
      end
      n_checks++;
      if (obs !== exp_vec) $display("FAIL reset_model got=%h exp=%h", obs, exp_vec);
      else n_pass++;
      rst = 1'b0;
   endtask

   task automatic test_steady_press();
      int first_rise = -1, n_rise = 0, n_fall = 0, rise_k = -1;
      do_reset();
      glitchy = 2'b01;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== exp_vec) $display("FAIL steady_model k=%0d got=%h exp=%h", k, obs, exp_vec);
         else n_pass++;
         if (dbl[0] && first_rise < 0) first_rise = k;
         if (rise[0]) begin n_rise++; rise_k = k; end
         if (fall != 2'b00) n_fall++;
      end
      n_checks++;
      if (first_rise !== 12) $display("FAIL steady_latency got=%0d exp=12", first_rise);
      else n_pass++;
      n_checks++;
      if (n_rise !== 1 || rise_k !== 12) $display("FAIL steady_rise_pulse count=%0d at=%0d exp=1 at 12", n_rise, rise_k);
      else n_pass++;
      n_checks++;
      if (n_fall !== 0) $display("FAIL steady_no_fall got=%0d exp=0", n_fall);
      else n_pass++;
   endtask

   task automatic test_glitch();
      logic [1:0] pat[$];
      int nh, k = 0;
      nh = $urandom_range(1, 2);
      for (int i = 0; i < nh; i++) pat.push_back({1'($urandom), 1'b1});
      pat.push_back({1'($urandom), 1'b0});
      for (int i = 0; i < 3; i++) pat.push_back({1'($urandom), 1'b1});
      do_reset();
      foreach (pat[t]) begin
         glitchy = pat[t];
         repeat (SCM) begin
            @(negedge clk);
            k++;
            n_checks++;
            if (obs !== exp_vec) $display("FAIL glitch_model k=%0d got=%h exp=%h", k, obs, exp_vec);
            else n_pass++;
         end
         n_checks++;
         if (dbl[0] !== (t == nh + 3)) $display("FAIL glitch_level tick=%0d got=%b exp=%b", t + 1, dbl[0], (t == nh + 3));
         else n_pass++;
      end
   endtask

   task automatic test_release();
      logic [1:0] pat[$] = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
      int k = 0, n_fall = 0, fall_k = -1;
      foreach (pat[t]) begin
         glitchy = pat[t];
         repeat (SCM) begin
            @(negedge clk);
            k++;
            n_checks++;
            if (obs !== exp_vec) $display("FAIL release_model k=%0d got=%h exp=%h", k, obs, exp_vec);
            else n_pass++;
            if (fall[0]) begin n_fall++; fall_k = k; end
         end
      end
      n_checks++;
      if (n_fall !== 1 || fall_k !== 28) $display("FAIL release_fall count=%0d at=%0d exp=1 at 28", n_fall, fall_k);
      else n_pass++;
      n_checks++;
      if (dbl[0] !== 1'b0) $display("FAIL release_level got=%b exp=0", dbl[0]);
      else n_pass++;
   endtask

   task automatic test_independence();
      logic [1:0] pat[$];
      int nt, k = 0, n_rise_cyc = 0, both_k = -1, n_fall = 0;
      nt = $urandom_range(4, 8);
      for (int i = 0; i < 3; i++) pat.push_back(2'b11);
      for (int i = 0; i < nt; i++) pat.push_back({1'(i % 2), 1'b1});
      do_reset();
      foreach (pat[t]) begin
         glitchy = pat[t];
         repeat (SCM) begin
            @(negedge clk);
            k++;
            n_checks++;
            if (obs !== exp_vec) $display("FAIL indep_model k=%0d got=%h exp=%h", k, obs, exp_vec);
            else n_pass++;
            if (rise != 2'b00) n_rise_cyc++;
            if (rise == 2'b11) both_k = k;
            if (fall != 2'b00) n_fall++;
         end
      end
      n_checks++;
      if (n_rise_cyc !== 1 || both_k !== 12) $display("FAIL indep_both_rise cycles=%0d at=%0d exp=1 at 12", n_rise_cyc, both_k);
      else n_pass++;
      n_checks++;
      if (dbl !== 2'b11 || n_fall !== 0) $display("FAIL indep_stable level=%b falls=%0d exp=11 0", dbl, n_fall);
      else n_pass++;
   endtask

   task automatic test_auto_repeat();
      int fall_k = -1;
      logic want;
      do_reset();
      for (int k = 1; k <= 48; k++) begin
         glitchy = (k <= 32) ? 2'b01 : 2'b00;
         @(negedge clk);
         n_checks++;
         if (obs !== exp_vec) $display("FAIL repeat_model k=%0d got=%h exp=%h", k, obs, exp_vec);
         else n_pass++;
         want = (k == 12) || (k >= 20 && k <= 40 && k % 4 == 0);
         n_checks++;
         if (press_r[0] !== want) $display("FAIL repeat_press k=%0d got=%b exp=%b", k, press_r[0], want);
         else n_pass++;
         if (fall_r[0]) fall_k = k;
      end
      n_checks++;
      if (fall_k !== 44) $display("FAIL repeat_fall at=%0d exp=44", fall_k);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int n_rpt1 = 0, first0 = -1;
      do_reset();
      for (int k = 1; k <= 30; k++) begin
         glitchy = (k <= 20) ? 2'b10 : 2'b11;
         @(negedge clk);
         n_checks++;
         if (obs !== exp_vec) $display("FAIL midrst_model k=%0d got=%h exp=%h", k, obs, exp_vec);
         else n_pass++;
         if (press_r[1]) n_rpt1++;
      end
      n_checks++;
      if (n_rpt1 !== 4 || dbl !== 2'b10) $display("FAIL midrst_setup presses=%0d level=%b exp=4 10", n_rpt1, dbl);
      else n_pass++;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (obs !== 16'h0000) $display("FAIL midrst_async_clear got=%h exp=0000", obs);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== exp_vec) $display("FAIL midrst_after_model k=%0d got=%h exp=%h", k, obs, exp_vec);
         else n_pass++;
         if (dbl[0] && first0 < 0) first0 = k;
         if (k < 12) begin
            n_checks++;
            if ({rise, fall, press, rise_r, fall_r, press_r} !== 12'h000)
               $display("FAIL midrst_spurious k=%0d got=%h exp=000", k, {rise, fall, press, rise_r, fall_r, press_r});
            else n_pass++;
         end
      end
      n_checks++;
      if (first0 !== 12) $display("FAIL midrst_recount got=%0d exp=12", first0);
      else n_pass++;
   endtask

   task automatic test_soak();
      do_reset();
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 5) == 0) glitchy = 2'($urandom);
         if (i == 400) #($urandom_range(1, 4)) rst = 1'b1;
         @(negedge clk);
         n_checks++;
         if (obs !== exp_vec) $display("FAIL soak_model i=%0d got=%h exp=%h", i, obs, exp_vec);
         else n_pass++;
         rst = 1'b0;
      end
   endtask

   initial begin
      test_reset();
      test_steady_press();
      test_glitch();
      test_release();
      test_independence();
      test_auto_repeat();
      test_reset_mid();
      test_soak();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
